// File: rtl/program_loader.sv
// program_loader: turns a byte stream into 16-bit words, writes them to consecutive program memory addresses, and holds the CPU in reset while loading.
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module program_loader #(
    parameter int                  PC_WIDTH          = 8,
    parameter int                  PROGRAM_DataWidth = 16,
    parameter int                  NumOpCodeBits     = 5,
    parameter logic [PC_WIDTH-1:0] BASE_ADR          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         prog_wr_en,
    output logic [PC_WIDTH-1:0]          prog_adr,
    output logic [PROGRAM_DataWidth-1:0] prog_data,
    output logic                         cpu_hold,
    output logic                         busy,
    output logic                         load_done,
    output logic                         load_error,
    output logic [7:0]                   rsvd_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t                         state_q, state_d;
    logic                           in_ready_q, in_ready_d;
    logic                           prog_wr_en_q, prog_wr_en_d;
    logic [PC_WIDTH-1:0]            prog_adr_q, prog_adr_d;
    logic [PROGRAM_DataWidth-1:0]   prog_data_q, prog_data_d;
    logic                           load_done_q, load_done_d;
    logic                           load_error_q, load_error_d;
    logic [7:0]                     rsvd_cnt_q, rsvd_cnt_d;
    logic [7:0]                     word_cnt_q, word_cnt_d;
    logic [7:0]                     index_q, index_d;
    logic [7:0]                     hi_q, hi_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]                     xor_q, xor_d;
`endif

    logic                           accept;
    logic                           last_word;
    logic [PROGRAM_DataWidth-1:0]   new_word;
    logic [NumOpCodeBits-1:0]       new_opcode;
    logic                           new_rsvd;

    assign accept     = in_valid & in_ready_q;
    assign last_word  = ((index_q + 8'd1) == word_cnt_q);
    assign new_word   = {hi_q, in_data};
    assign new_opcode = new_word[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign new_rsvd   = ((new_opcode >= 5'b01011) && (new_opcode <= 5'b01111)) ||
                        (new_opcode >= 5'b10110);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // abort dominates every other event, including a coincident start
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: if (start) state_d = S_LEN;
                S_LEN:  if (accept) state_d = (in_data == 8'd0) ? S_ERR : S_HI;
                S_HI:   if (accept) state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
                S_LO:   if (accept) state_d = last_word ? S_CHK : S_HI;
                S_CHK:  if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
`else
                S_LO:   if (accept) state_d = last_word ? S_DONE : S_HI;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        word_cnt_d   = word_cnt_q;
        index_d      = index_q;
        hi_d         = hi_q;
        prog_wr_en_d = 1'b0;
        prog_adr_d   = prog_adr_q;
        prog_data_d  = prog_data_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;
        rsvd_cnt_d   = rsvd_cnt_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d        = xor_q;
`endif
        in_ready_d   = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        if (!abort) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        load_done_d  = 1'b0;
                        load_error_d = 1'b0;
                        rsvd_cnt_d   = 8'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        word_cnt_d = in_data;
                        index_d    = 8'd0;
`ifdef LOADER_CHECKSUM_EN
                        xor_d      = in_data;
`endif
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_d = in_data;
`ifdef LOADER_CHECKSUM_EN
                        xor_d = xor_q ^ in_data;
`endif
                    end
                end
                // the write strobe lands in the cycle after the low byte, overlapping the next high byte
                S_LO: begin
                    if (accept) begin
                        prog_wr_en_d = 1'b1;
                        prog_adr_d   = BASE_ADR + PC_WIDTH'(index_q);
                        prog_data_d  = new_word;
                        index_d      = index_q + 8'd1;
                        if (new_rsvd && (rsvd_cnt_q != 8'hFF)) begin
                            rsvd_cnt_d = rsvd_cnt_q + 8'd1;
                        end
`ifdef LOADER_CHECKSUM_EN
                        xor_d = xor_q ^ in_data;
`endif
                    end
                end
                default: ;
            endcase
            if (state_d == S_DONE) load_done_d  = 1'b1;
            if (state_d == S_ERR)  load_error_d = 1'b1;
        end
    end

    always_comb begin
        busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
        cpu_hold = busy | prog_wr_en_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            prog_wr_en_q <= 1'b0;
            prog_adr_q   <= '0;
            prog_data_q  <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            rsvd_cnt_q   <= 8'd0;
            word_cnt_q   <= 8'd0;
            index_q      <= 8'd0;
            hi_q         <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            in_ready_q   <= in_ready_d;
            prog_wr_en_q <= prog_wr_en_d;
            prog_adr_q   <= prog_adr_d;
            prog_data_q  <= prog_data_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
            rsvd_cnt_q   <= rsvd_cnt_d;
            word_cnt_q   <= word_cnt_d;
            index_q      <= index_d;
            hi_q         <= hi_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q        <= xor_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign prog_wr_en = prog_wr_en_q;
    assign prog_adr   = prog_adr_q;
    assign prog_data  = prog_data_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;
    assign rsvd_cnt   = rsvd_cnt_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction path. Receives a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes each word into program memory at consecutive addresses. The instruction decoder later reads and decodes these words.
- Holds the CPU in reset while loading. Flags words whose opcode field is reserved.

Parameters:
PC_WIDTH, 8, program memory address width
PROGRAM_DataWidth, 16, instruction word width (fixed two bytes, high byte first)
NumOpCodeBits, 5, opcode field width, located in word[15:11]
BASE_ADR, 0, address of the first written word

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a load; ignored while busy=1
abort  input  1  level; forces return to IDLE on the next edge, overriding all other events
in_data  input  8  stream byte
in_valid  input  1  in_data is valid
in_ready  output  1  loader accepts a byte this cycle
prog_wr_en  output  1  program memory write strobe, one cycle per word
prog_adr  output  PC_WIDTH  program memory write address
prog_data  output  16  instruction word to write
cpu_hold  output  1  holds the CPU in reset; high while busy
busy  output  1  state is not IDLE, DONE or ERR
load_done  output  1  sticky; last load completed successfully
load_error  output  1  sticky; last load failed
rsvd_cnt  output  8  count of written words with a reserved opcode, saturating at 255

Behaviour:
- Reset values: all outputs 0; state IDLE; internal word counter 0.
- Byte transfer rule: a byte is accepted at the rising edge where in_valid=1 and in_ready=1. in_ready is a registered function of state only: 1 in LEN, HI, LO and CHK, 0 otherwise. in_ready has no combinational path from in_valid.
- States: IDLE, LEN, HI, LO, CHK (macro only), DONE, ERR.
- IDLE/DONE/ERR + start -> LEN. On entering LEN: clear load_done, load_error and rsvd_cnt.
- LEN: accepted byte N is the word count.
  - N=0 -> ERR.
  - Otherwise store N, set index=0, go to HI.
- HI: accepted byte latched as word[15:8]; go to LO.
- LO: accepted byte becomes word[7:0].
  - On the next cycle: prog_wr_en=1 for exactly one cycle, prog_adr=BASE_ADR+index (wraps modulo 2^PC_WIDTH), prog_data=full word.
  - Then index increments.
  - If index+1==N, go to DONE (or CHK with the macro); else go to HI.
  - Back-to-back bytes sustain 1 byte/cycle. The write pulse overlaps acceptance of the next HI byte.
- Reserved opcodes: 01011-01111 and 10110-11111. A word with a reserved opcode is still written, and rsvd_cnt increments in the same cycle as prog_wr_en.
- DONE: load_done=1 and cpu_hold=0. Both persist until the next start.
- ERR: load_error=1 and cpu_hold=0. Both persist until the next start.
- abort in any state -> IDLE:
  - The pending write pulse is suppressed if the word has not been written yet.
  - load_done and load_error are left unchanged.
- start and abort in the same cycle: abort wins.
- in_valid while in_ready=0: the byte is ignored, not buffered.
- reset mid-load: immediate return to IDLE with all outputs 0. Words already written remain in memory.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - A running XOR of all accepted bytes, including N, is kept.
  - After the last LO byte the loader enters CHK and accepts one more byte.
  - If that byte equals the running XOR -> DONE; otherwise -> ERR. All N words have already been written in either case.
- LOADER_CHECKSUM_EN undefined: no CHK state and no checksum logic. Last LO byte -> DONE.

Test Plan:
- start, then bytes 02,08,A5,01,23 back-to-back -> writes adr0=0x08A5 (VAL), adr1=0x0123 (ADD); load_done=1; rsvd_cnt=0; cpu_hold falls after the last write.
- start, then byte 00 -> no prog_wr_en pulses; load_error=1; load_done=0.
- start, N=01, word 0x5800 (opcode 01011) -> word written at adr0; rsvd_cnt=1; load_done=1.
- start, N=03, abort asserted after the first HI byte of word 2 -> exactly one write (adr0); state IDLE; busy=0; no further writes.
- in_valid toggled randomly with N=04 -> four writes at adr0..3 carrying the correct words; no byte dropped or duplicated; start pulses during the load are ignored.
- With LOADER_CHECKSUM_EN: bytes 01,12,34, then checksum 27 -> load_done=1. Same stream with checksum 00 -> load_error=1 and the word is still written.
